secuenciador_filtro: RTL and testbench

- Sample-rate scheduler for the second-order filter datapath.
- Each sample period it:
  - requests an ADC conversion and waits for it;
  - pulses the delay-line shift strobe so fk/fk_1/fk_2 advance;
  - steps the MAC through all coefficient taps;
  - hands the result to the DAC with a req/ack handshake.
- Sits between the converter interfaces and the datapath (delay line, coefficient ROM, MAC accumulator, output register).

---
 rtl/filtro_pkg.sv | 18 +
 rtl/divisor_muestreo.sv | 28 ++
 rtl/secuenciador_filtro.sv | 132 +++++++++++++
 tb/tb_secuenciador_filtro.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// Shared definitions for the filter sample-rate scheduler: defaults and FSM state encoding.
package filtro_pkg;
  localparam int FS_DIV_DEF = 2000;
  localparam int DIV_W_DEF  = 16;
  localparam int TAPS_DEF   = 5;
  localparam int TAP_W_DEF  = 3;
  localparam int ADC_TO_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADC_REQ,
    ST_ADC_WAIT,
    ST_SHIFT,
    ST_MAC,
    ST_LOAD,
    ST_DAC
  } estado_t;
endpackage

// File: rtl/divisor_muestreo.sv
// Sample-period counter: free-runs 0..FS_DIV-1 while enabled, tick on the last count.
module divisor_muestreo
  import filtro_pkg::*;
#(
  parameter int FS_DIV = FS_DIV_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);
  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(FS_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Dropping enable parks the count at 0 so a restart always yields a full period.
  always_comb begin
    tick  = enable && (cnt_q == CNT_LAST);
    cnt_d = '0;
    if (enable && !tick) cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/secuenciador_filtro.sv
// Per-sample scheduler: ADC request/wait, delay-line shift, MAC tap sweep, output load, DAC handshake.
module secuenciador_filtro
  import filtro_pkg::*;
#(
  parameter int FS_DIV = FS_DIV_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int TAPS   = TAPS_DEF,
  parameter int TAP_W  = TAP_W_DEF,
  parameter int ADC_TO = ADC_TO_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic             adc_start,
  input  logic             adc_done,
  output logic             shift,
  output logic [TAP_W-1:0] tap_sel,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             y_load,
  output logic             dac_req,
  input  logic             dac_ack,
  output logic             busy,
  output logic             overrun,
  output logic             adc_timeout
);
  localparam int               WAIT_W    = $clog2(ADC_TO + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ADC_TO - 1);
  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(TAPS - 1);

  logic tick;

  estado_t           state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic              overrun_q, overrun_d;
  logic              adc_timeout_q, adc_timeout_d;
  logic              adc_start_q, adc_start_d;
  logic              shift_q, shift_d;
  logic              acc_en_q, acc_en_d;
  logic              y_load_q, y_load_d;
  logic              dac_req_q, dac_req_d;
  logic              busy_q, busy_d;

  divisor_muestreo #(
    .FS_DIV (FS_DIV),
    .DIV_W  (DIV_W)
  ) u_divisor (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick)
  );

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    tap_d         = '0;
    adc_timeout_d = adc_timeout_q;
    // A tick that finds the scheduler busy is lost, only flagged.
    overrun_d     = overrun_q | (tick && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE:     if (tick) state_d = ST_ADC_REQ;
      ST_ADC_REQ:  state_d = ST_ADC_WAIT;
      ST_ADC_WAIT: begin
        if (adc_done) begin
          state_d = ST_SHIFT;
        end else if (wait_q == WAIT_LAST) begin
          state_d       = ST_IDLE;
          adc_timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_SHIFT:    state_d = ST_MAC;
      ST_MAC: begin
        if (tap_q == TAP_LAST) state_d = ST_LOAD;
        else                   tap_d   = tap_q + TAP_W'(1);
      end
      ST_LOAD:     state_d = ST_DAC;
      ST_DAC:      if (dac_ack) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they are flops aligned with the state.
    adc_start_d = (state_d == ST_ADC_REQ);
    shift_d     = (state_d == ST_SHIFT);
    acc_en_d    = (state_d == ST_MAC);
    y_load_d    = (state_d == ST_LOAD);
    dac_req_d   = (state_d == ST_DAC);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wait_q        <= '0;
      tap_q         <= '0;
      overrun_q     <= 1'b0;
      adc_timeout_q <= 1'b0;
      adc_start_q   <= 1'b0;
      shift_q       <= 1'b0;
      acc_en_q      <= 1'b0;
      y_load_q      <= 1'b0;
      dac_req_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      tap_q         <= tap_d;
      overrun_q     <= overrun_d;
      adc_timeout_q <= adc_timeout_d;
      adc_start_q   <= adc_start_d;
      shift_q       <= shift_d;
      acc_en_q      <= acc_en_d;
      y_load_q      <= y_load_d;
      dac_req_q     <= dac_req_d;
      busy_q        <= busy_d;
    end
  end

  assign adc_start   = adc_start_q;
  assign shift       = shift_q;
  assign acc_clr     = shift_q;
  assign tap_sel     = tap_q;
  assign acc_en      = acc_en_q;
  assign y_load      = y_load_q;
  assign dac_req     = dac_req_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign adc_timeout = adc_timeout_q;
endmodule

// File: tb/tb_secuenciador_filtro.sv
// Randomized bench for secuenciador_filtro against a per-sample timeline model.
module tb_secuenciador_filtro;
  localparam int FS = 20;
  localparam int TO = 8;
  localparam int NT = 5;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0, enable = 1'b0, adc_done = 1'b0, dac_ack = 1'b0;
  logic adc_start, shift, acc_clr, acc_en, y_load, dac_req, busy, overrun, adc_timeout;
  logic [TW-1:0] tap_sel;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  // Model: one active sample described by its start cycle s, done delay d (0 = never),
  // ack delay a and first idle cycle e; plus sticky flags and the enabled-run length.
  bit have = 0, ov = 0, to = 0, noise = 0;
  int s = 0, d = 0, a = 0, e = 0, run = 0;
  int want_d = -1, want_a = -1;

  always #5 clk = ~clk;

  secuenciador_filtro #(
    .FS_DIV (FS), .DIV_W (16), .TAPS (NT), .TAP_W (TW), .ADC_TO (TO)
  ) dut (
    .clk (clk), .reset_n (reset_n), .enable (enable),
    .adc_start (adc_start), .adc_done (adc_done), .shift (shift),
    .tap_sel (tap_sel), .acc_clr (acc_clr), .acc_en (acc_en), .y_load (y_load),
    .dac_req (dac_req), .dac_ack (dac_ack), .busy (busy),
    .overrun (overrun), .adc_timeout (adc_timeout)
  );

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h want %h", tag, cyc, got, exp);
  endtask

  // {adc_start, shift, tap_sel, acc_clr, acc_en, y_load, dac_req, busy, overrun, adc_timeout}
  function automatic logic [11:0] expect_out(int c);
    logic st, sh, ae, yl, dr, bz;
    logic [TW-1:0] ts;
    int m;
    st = 0; sh = 0; ae = 0; yl = 0; dr = 0; bz = 0; ts = '0;
    if (have && c >= s && c < e) begin
      bz = 1;
      st = (c == s);
      if (d > 0) begin
        m  = s + d;
        sh = (c == m + 1);
        ae = (c >= m + 2) && (c <= m + 1 + NT);
        if (ae) ts = 3'(c - m - 2);
        yl = (c == m + NT + 2);
        dr = (c >= m + NT + 3);
      end
    end
    return {st, sh, ts, sh, ae, yl, dr, bz, ov, to};
  endfunction

  task automatic step(bit rst, bit en);
    logic [11:0] exp_v;
    bit tick, dn, ak, wait_win, dac_win;
    @(negedge clk);
    exp_v = expect_out(cyc);
    check_eq("outs", {adc_start, shift, tap_sel, acc_clr, acc_en, y_load, dac_req,
                      busy, overrun, adc_timeout}, exp_v);
    wait_win = have && cyc >= s + 1 && cyc <= ((d > 0) ? s + d : s + TO);
    dac_win  = have && d > 0 && cyc >= s + d + NT + 3 && cyc < e;
    dn = have && d > 0 && cyc == s + d;
    ak = dac_win && cyc == e - 1;
    if (noise) begin
      if (!wait_win && $urandom_range(0, 3) == 0) dn = 1;
      if (!dac_win && $urandom_range(0, 3) == 0) ak = 1;
    end
    reset_n  = !rst;
    enable   = en;
    adc_done = dn;
    dac_ack  = ak;
    if (rst) begin
      have = 0; ov = 0; to = 0; run = 0;
    end else begin
      run  = en ? run + 1 : 0;
      tick = en && (run % FS == 0);
      if (have && d == 0 && cyc == s + TO) to = 1;
      if (tick) begin
        if (have && cyc >= s && cyc < e) ov = 1;
        else begin
          have = 1;
          s = cyc + 1;
          d = (want_d >= 0) ? want_d
              : (($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TO)));
          a = (want_a >= 0) ? want_a : int'($urandom_range(0, 25));
          e = (d > 0) ? s + d + NT + 4 + a : s + TO + 1;
        end
      end
    end
    cyc++;
  endtask

  initial begin
    bit hit, en;
    repeat (3) step(1, 0);
    repeat (3 * FS) step(0, 0);

    want_d = 4; want_a = 2;
    repeat (5 * FS + 2) step(0, 1);

    want_d = 0;
    repeat (2 * FS) step(0, 1);
    want_d = 4;
    repeat (2 * FS) step(0, 1);

    want_a = 30;
    repeat (4 * FS) step(0, 1);
    want_a = 2;
    repeat (2 * FS) step(0, 1);

    hit = 0;
    for (int k = 0; k < 4 * FS && !hit; k++) begin
      hit = have && d > 0 && cyc == s + d + 4;
      step(hit, 1);
    end
    check_eq("mac_reset_reached", 32'(hit), 32'd1);
    repeat (3 * FS) step(0, 1);

    hit = 0;
    for (int k = 0; k < 3 * FS && !hit; k++) begin
      hit = have && d > 0 && cyc >= s + 1 && cyc <= s + d;
      step(0, !hit);
    end
    check_eq("adc_wait_reached", 32'(hit), 32'd1);
    repeat (4 * FS) step(0, 0);

    noise = 1; want_d = -1; want_a = -1; en = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 149) == 0) en = !en;
      step($urandom_range(0, 399) == 0, en);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
